// File: rtl/local_ni_tx_if.sv
// Core-side and router-side signal bundle of the local injection network interface.
// The NI takes the slave view; the core/router environment takes the master view.
interface local_ni_tx_if #(
  parameter int unsigned CNT_W = 4
);
  logic             core_req_i;
  logic [15:0]      core_dest_i;
  logic             core_ack_o;
  logic [15:0]      core_data_i;
  logic             core_data_valid_i;
  logic             core_data_ready_o;
  logic [15:0]      l_data_o;
  logic             l_valid_o;
  logic             l_credit_i;
  logic             busy_o;
  logic [CNT_W-1:0] credit_cnt_o;
  logic             credit_err_o;

  modport master (
    output core_req_i, core_dest_i, core_data_i, core_data_valid_i, l_credit_i,
    input  core_ack_o, core_data_ready_o, l_data_o, l_valid_o, busy_o,
           credit_cnt_o, credit_err_o
  );

  modport slave (
    input  core_req_i, core_dest_i, core_data_i, core_data_valid_i, l_credit_i,
    output core_ack_o, core_data_ready_o, l_data_o, l_valid_o, busy_o,
           credit_cnt_o, credit_err_o
  );
endinterface

// File: rtl/local_ni_tx.sv
// Local-port injection NI: packetizes core messages into header + body flits and
// injects them into the router's local input buffer under credit-based flow control.
module local_ni_tx #(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned PKT_FLITS = 4,
  parameter int unsigned CNT_W     = 4
) (
  input logic          clk,
  input logic          reset,
  local_ni_tx_if.slave ni
);

  localparam int unsigned BODY_W = $clog2(PKT_FLITS);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  credit_cnt;
  logic [BODY_W-1:0] body_cnt;
  logic [15:0]       dest_q;
  logic [15:0]       l_data;
  logic              l_valid;
  logic              credit_err;

  logic have_credit;
  logic head_send;
  logic body_send;
  logic send;

  // Eligibility looks only at the registered count; returned credit is usable next cycle.
  assign have_credit = (credit_cnt != '0);
  assign head_send   = (state == HEAD) && have_credit;
  assign body_send   = (state == BODY) && have_credit && ni.core_data_valid_i;
  assign send        = head_send || body_send;

  assign ni.core_ack_o        = (state == IDLE) && ni.core_req_i;
  assign ni.core_data_ready_o = (state == BODY) && have_credit;
  assign ni.busy_o            = (state != IDLE);
  assign ni.credit_cnt_o      = credit_cnt;
  assign ni.l_data_o          = l_data;
  assign ni.l_valid_o         = l_valid;
  assign ni.credit_err_o      = credit_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      credit_cnt <= CNT_W'(BUF_DEPTH);
      body_cnt   <= '0;
      dest_q     <= '0;
      l_data     <= '0;
      l_valid    <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      l_valid <= send;
      if (head_send) begin
        l_data <= dest_q;
      end else if (body_send) begin
        l_data <= ni.core_data_i;
      end

      // A send and a returned credit in the same cycle cancel out.
      if (send && !ni.l_credit_i) begin
        credit_cnt <= credit_cnt - CNT_W'(1);
      end else if (!send && ni.l_credit_i) begin
        if (credit_cnt == CNT_W'(BUF_DEPTH)) begin
          credit_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (ni.core_req_i) begin
            dest_q <= ni.core_dest_i;
            state  <= HEAD;
          end
        end
        HEAD: begin
          if (have_credit) begin
            body_cnt <= BODY_W'(PKT_FLITS - 1);
            state    <= BODY;
          end
        end
        BODY: begin
          if (body_send) begin
            body_cnt <= body_cnt - BODY_W'(1);
            if (body_cnt == BODY_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_ni_tx.sv
// Bench for local_ni_tx: table of packet scenarios plus hand-written stall, reset and
// credit-overflow sequences; every injected flit is checked against a scoreboard queue.
module tb_local_ni_tx;

  localparam int unsigned BUF_DEPTH = 8;
  localparam int unsigned PKT_FLITS = 4;
  localparam int unsigned CNT_W     = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  local_ni_tx_if #(.CNT_W(CNT_W)) ni ();

  local_ni_tx #(
    .BUF_DEPTH(BUF_DEPTH),
    .PKT_FLITS(PKT_FLITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ni   (ni)
  );

  typedef struct {
    logic [15:0] data;
    int          delta;   // required cycles since previous flit, 0 = unchecked
  } exp_t;

  typedef struct {
    bit          rst;
    logic [15:0] dest;
    logic [15:0] base;
    int          gap;
    bit          ret;
    int          exp_cnt;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[5];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_flit_cyc = -100;
  int acks = 0;
  int exp_pkts = 0;
  bit ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every valid flit must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (ni.core_ack_o) acks++;
      if (ni.l_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_flit: got %0h expected no flit (t=%0t)", ni.l_data_o, $time);
        end else begin
          e = sb.pop_front();
          check("flit_data", ni.l_data_o, e.data);
          if (e.delta > 0) check("flit_spacing", cyc - last_flit_cyc, e.delta);
        end
        last_flit_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    ni.core_req_i = 0;
    ni.core_data_valid_i = 0;
    ni.l_credit_i = 0;
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("rst_l_valid", ni.l_valid_o, 0);
    check("rst_l_data", ni.l_data_o, 0);
    check("rst_busy", ni.busy_o, 0);
    check("rst_credit_cnt", ni.credit_cnt_o, BUF_DEPTH);
    check("rst_credit_err", ni.credit_err_o, 0);
    check("rst_ready", ni.core_data_ready_o, 0);
    check("rst_ack", ni.core_ack_o, 0);
    sb.delete();
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic request(input logic [15:0] d, output bit acked);
    ni.core_req_i  = 1;
    ni.core_dest_i = d;
    #1;
    acked = 0;
    for (int i = 0; i < 20; i++) begin
      if (ni.core_ack_o) begin
        acked = 1;
        break;
      end
      tick();
    end
    if (!acked) fail("ack_timeout");
    sb.push_back('{d, 0});
    exp_pkts++;
    tick();
    ni.core_req_i  = 0;
    ni.core_dest_i = 16'hFFFF;
  endtask

  task automatic send_head(input bit ret);
    for (int i = 0; i < 50; i++) begin
      if (ni.credit_cnt_o != 0) begin
        ni.l_credit_i = ret;
        tick();
        ni.l_credit_i = 0;
        return;
      end
      tick();
    end
    fail("head_timeout");
  endtask

  task automatic feed_body(input logic [15:0] base, input int gap, input bit ret, input bit chk);
    bit done;
    for (int w = 1; w < PKT_FLITS; w++) begin
      ni.core_data_valid_i = 0;
      repeat (gap) tick();
      ni.core_data_valid_i = 1;
      ni.core_data_i = base + 16'(w);
      sb.push_back('{base + 16'(w), chk ? gap + 1 : 0});
      done = 0;
      for (int i = 0; i < 50; i++) begin
        if (ni.core_data_ready_o) begin
          if (ret) ni.l_credit_i = 1;
          tick();
          if (ret) ni.l_credit_i = 0;
          done = 1;
          break;
        end
        tick();
      end
      if (!done) fail("body_timeout");
    end
    ni.core_data_valid_i = 0;
    ni.core_data_i = 16'h0;
  endtask

  task automatic settle_check(input int exp_cnt, input bit exp_err);
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    check("credit_cnt", ni.credit_cnt_o, exp_cnt);
    check("busy_idle", ni.busy_o, 0);
    check("credit_err", ni.credit_err_o, exp_err);
    check("ack_count", acks, exp_pkts);
  endtask

  task automatic run_vec(input int i);
    if (vt[i].rst) do_reset();
    request(vt[i].dest, ok);
    send_head(vt[i].ret);
    feed_body(vt[i].base, vt[i].gap, vt[i].ret, 1);
    settle_check(vt[i].exp_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    ni.core_req_i = 0;
    ni.core_dest_i = 0;
    ni.core_data_i = 0;
    ni.core_data_valid_i = 0;
    ni.l_credit_i = 0;

    vt[0] = '{1, 16'h0102, 16'hA000, 0, 0, 4};  // single packet, full credit
    vt[1] = '{0, 16'h0203, 16'hB000, 0, 0, 0};  // second packet drains credit
    vt[2] = '{1, 16'h0405, 16'hD000, 0, 1, 8};  // credit returned on every send
    vt[3] = '{0, 16'h0506, 16'hE000, 3, 0, 4};  // 3-cycle valid gaps
    vt[4] = '{0, 16'h0607, 16'hF000, 1, 1, 4};  // gaps with credit return

    for (int i = 0; i < 2; i++) run_vec(i);

    // Third request with zero credit: acked, then parked in HEAD
    request(16'h0304, ok);
    repeat (3) begin
      check("stall_busy", ni.busy_o, 1);
      check("stall_l_valid", ni.l_valid_o, 0);
      check("stall_cnt", ni.credit_cnt_o, 0);
      tick();
    end
    ni.l_credit_i = 1;
    tick();
    ni.l_credit_i = 0;
    check("cnt_after_pulse", ni.credit_cnt_o, 1);
    check("head_not_yet", ni.l_valid_o, 0);
    tick();
    check("head_after_pulse_valid", ni.l_valid_o, 1);
    check("head_after_pulse_data", ni.l_data_o, 16'h0304);
    check("cnt_after_head", ni.credit_cnt_o, 0);
    fork
      feed_body(16'hC000, 0, 0, 0);
      begin
        ni.l_credit_i = 1;
        repeat (8) tick();
        ni.l_credit_i = 0;
      end
    join
    settle_check(5, 0);

    for (int i = 2; i < 5; i++) run_vec(i);

    // Reset after header and one body flit drops the rest of the packet
    request(16'h0708, ok);
    send_head(0);
    ni.core_data_valid_i = 1;
    ni.core_data_i = 16'h9001;
    sb.push_back('{16'h9001, 1});
    tick();
    ni.core_data_valid_i = 0;
    @(negedge clk);
    #1;
    check("pre_reset_valid", ni.l_valid_o, 1);
    check("pre_reset_busy", ni.busy_o, 1);
    reset = 0;
    #1;
    check("mid_rst_l_valid", ni.l_valid_o, 0);
    check("mid_rst_l_data", ni.l_data_o, 0);
    check("mid_rst_cnt", ni.credit_cnt_o, BUF_DEPTH);
    check("mid_rst_busy", ni.busy_o, 0);
    check("mid_rst_ready", ni.core_data_ready_o, 0);
    check("mid_rst_sb", sb.size(), 0);
    tick();
    tick();
    reset = 1;
    tick();
    request(16'h0809, ok);
    send_head(0);
    feed_body(16'h5500, 0, 0, 1);
    settle_check(4, 0);

    // Surplus credit at full count is flagged and sticks
    do_reset();
    ni.l_credit_i = 1;
    tick();
    ni.l_credit_i = 0;
    check("overflow_err", ni.credit_err_o, 1);
    check("overflow_cnt", ni.credit_cnt_o, BUF_DEPTH);
    repeat (5) tick();
    check("overflow_err_sticky", ni.credit_err_o, 1);
    request(16'h0A0B, ok);
    send_head(0);
    feed_body(16'h6600, 0, 0, 1);
    settle_check(4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
